// File: rtl/byte_serial_sender_pkg.sv
// -----------------------------------------------------------------------------
// byte_serial_sender_pkg
// Shared definitions for the scanner-to-transfer-center serial link. The
// transfer center receiver imports the same framing constants, so both ends
// of the line agree on what a frame looks like.
// -----------------------------------------------------------------------------
package byte_serial_sender_pkg;

  // Transmit FSM encoding (2 bits).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  // Frame: one START_BIT, DATA_BITS data bits MSB-first, one STOP_BIT.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/byte_serial_sender_if.sv
// -----------------------------------------------------------------------------
// byte_serial_sender_if
// Bundles the scanner load port, the transfer-center serial side and the
// status outputs of byte_serial_sender.
//   load_valid/load_data/load_ready : byte load handshake from the scanner
//   ready_for_transfer_in           : remote side ready to take a frame
//   data_out                        : registered serial line
//   busy/bit_count/fifo_count/frames_sent : status
// slave  = the sender itself, master = whatever drives the load port and
// watches the line.
// -----------------------------------------------------------------------------
interface byte_serial_sender_if #(
  parameter int CNT_W = 3
);
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_ready;
  logic             ready_for_transfer_in;
  logic             data_out;
  logic             busy;
  logic [2:0]       bit_count;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       frames_sent;

  modport slave (
    input  load_valid, load_data, ready_for_transfer_in,
    output load_ready, data_out, busy, bit_count, fifo_count, frames_sent
  );

  modport master (
    output load_valid, load_data, ready_for_transfer_in,
    input  load_ready, data_out, busy, bit_count, fifo_count, frames_sent
  );
endinterface

// File: rtl/byte_serial_sender_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Circular byte buffer with wrapping read/write pointers.
//   clk, rst  : clock, asynchronous active-high reset (flushes the buffer)
//   push      : write push_data this edge (ignored when full)
//   pop       : drop the head byte this edge (ignored when empty)
//   pop_data  : head byte, valid whenever !empty (show-ahead)
//   count     : bytes held, 0..DEPTH
//   full/empty: count == DEPTH / count == 0
// Push and pop on the same edge are both honoured and leave count unchanged.
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign pop_data = mem[rdPtr];

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are meaningful, and leaving the array unreset lets it map
  // onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= push_data;
  end

  // NOTE: sequential state is updated with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_serial_sender.sv
// -----------------------------------------------------------------------------
// byte_serial_sender
// Buffers scanner bytes in a small FIFO and, whenever the remote transfer
// center is ready, shifts each one out as a 10-bit frame:
// START_BIT, 8 data bits MSB-first, STOP_BIT.
//   clk, rst : clock, asynchronous active-high reset (aborts any frame and
//              flushes the FIFO)
//   bus      : byte_serial_sender_if.slave -- load port, serial line, status
// -----------------------------------------------------------------------------
module byte_serial_sender
  import byte_serial_sender_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_serial_sender_if.slave  bus
);

  txState_t         state;
  txState_t         nextState;
  logic [7:0]       shiftReg;
  logic [7:0]       nextShift;
  logic [2:0]       bitCnt;
  logic [2:0]       nextBitCnt;
  logic             dataOut;
  logic             nextDataOut;
  logic [7:0]       framesSent;

  logic             fifoPush;
  logic             fifoPop;
  logic [7:0]       fifoHead;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull;
  logic             fifoEmpty;

  // load_ready comes from the registered count only; no bypass to the line.
  assign fifoPush = bus.load_valid && !fifoFull;

  byte_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifoPush),
    .push_data (bus.load_data),
    .pop       (fifoPop),
    .pop_data  (fifoHead),
    .count     (fifoCount),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    nextState  = state;
    nextShift  = shiftReg;
    nextBitCnt = bitCnt;
    fifoPop    = 1'b0;

    case (state)
      IDLE: begin
        if (!fifoEmpty && bus.ready_for_transfer_in) begin
          fifoPop   = 1'b1;
          nextShift = fifoHead;
          nextState = START;
        end
      end
      START: begin
        nextState  = DATA;
        nextBitCnt = 3'(DATA_BITS - 1);
      end
      DATA: begin
        if (bitCnt == 3'd0) nextState  = STOP;
        else                nextBitCnt = bitCnt - 3'd1;
      end
      STOP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // The line is registered: compute the level for the state being entered.
    case (nextState)
      START:   nextDataOut = START_BIT;
      DATA:    nextDataOut = nextShift[nextBitCnt];
      default: nextDataOut = STOP_BIT;  // STOP and IDLE both hold the line low
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      dataOut    <= 1'b0;
      framesSent <= '0;
    end else begin
      state    <= nextState;
      shiftReg <= nextShift;
      bitCnt   <= nextBitCnt;
      dataOut  <= nextDataOut;
      // Counted on the STOP -> IDLE edge, so an aborted frame never counts.
      if (state == STOP) framesSent <= framesSent + 8'd1;
    end
  end

  assign bus.load_ready  = !fifoFull;
  assign bus.data_out    = dataOut;
  assign bus.busy        = (state != IDLE);
  assign bus.bit_count   = bitCnt;
  assign bus.fifo_count  = fifoCount;
  assign bus.frames_sent = framesSent;

endmodule

// File: tb/tb_byte_serial_sender.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_sender
// Scoreboard bench: every accepted byte is queued when it is loaded and
// popped when its frame is captured from data_out. Inputs change 1 ns after
// posedge, outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_byte_serial_sender;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  byte_serial_sender_if #(.CNT_W(CNT_W)) bus ();

  byte_serial_sender #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         testsRun  = 0;
  int         failCnt   = 0;
  logic [7:0] expQ[$];
  logic [7:0] expFrames = 8'd0;

  // Reset view: data_out, busy, bit_count, fifo_count, frames_sent, load_ready.
  localparam logic [16:0] RESET_VIEW = {1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for one cycle; expAccept is what the bench expects of
  // load_ready on that cycle. Starts and ends 1 ns after a posedge.
  task automatic push_byte(input logic [7:0] b, input logic expAccept, input string tag);
    logic accepted;
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    @(negedge clk);
    accepted = bus.load_ready;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    testsRun++;
    if (accepted !== expAccept) begin
      failCnt++;
      $display("FAIL %s load_ready: got %0b want %0b", tag, accepted, expAccept);
    end
    if (expAccept) expQ.push_back(b);
  endtask

  // Wait (bounded) for busy, then capture 10 line bits. Checks frame shape:
  // line low while waiting, busy high throughout, bit_count 7..0 in DATA.
  // Returns at the negedge inside the STOP cycle.
  task automatic recv_frame(input int budget, output logic [9:0] bits,
                            output logic shapeOk, output int waited,
                            output logic timedOut);
    int expBc;
    bits     = '0;
    shapeOk  = 1'b1;
    waited   = 0;
    timedOut = 1'b0;
    @(negedge clk);
    while (bus.busy !== 1'b1) begin
      if (bus.data_out !== 1'b0) shapeOk = 1'b0;
      waited++;
      if (waited >= budget) begin
        timedOut = 1'b1;
        return;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      bits[9-i] = bus.data_out;
      expBc = (i >= 1 && i <= 8) ? (8 - i) : 0;
      if (bus.busy !== 1'b1 || bus.bit_count !== 3'(expBc)) shapeOk = 1'b0;
    end
  endtask

  // Capture one frame and score it against the head of the queue.
  // expWait < 0 means the idle time before the frame is not checked.
  task automatic score_frame(input string tag, input int expWait);
    logic [9:0] bits;
    logic       shapeOk;
    int         waited;
    logic       timedOut;
    logic [7:0] expByte;
    logic [9:0] expBits;
    recv_frame(200, bits, shapeOk, waited, timedOut);
    testsRun++;
    if (timedOut) begin
      failCnt++;
      $display("FAIL %s frame: got no frame within 200 cycles, want a frame", tag);
      return;
    end
    if (expQ.size() == 0) begin
      failCnt++;
      $display("FAIL %s frame: got bits %b, want no frame", tag, bits);
      return;
    end
    expByte = expQ.pop_front();
    expBits = {1'b1, expByte, 1'b0};
    if (bits !== expBits || shapeOk !== 1'b1) begin
      failCnt++;
      $display("FAIL %s frame: got bits %b shape_ok %0b, want bits %b shape_ok 1",
               tag, bits, shapeOk, expBits);
    end
    expFrames++;
    if (expWait >= 0) begin
      testsRun++;
      if (waited !== expWait) begin
        failCnt++;
        $display("FAIL %s idle cycles before frame: got %0d want %0d", tag, waited, expWait);
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] view;
    #1;
    view = {bus.data_out, bus.busy, bus.bit_count, bus.fifo_count, bus.frames_sent, bus.load_ready};
    testsRun++;
    if (view !== RESET_VIEW) begin
      failCnt++;
      $display("FAIL reset_initial: got %b want %b", view, RESET_VIEW);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    // Buffer a byte, then reset between edges: the flush must be immediate.
    push_byte(8'h77, 1'b1, "reset_preload");
    testsRun++;
    if (bus.fifo_count !== CNT_W'(1)) begin
      failCnt++;
      $display("FAIL reset_preload fifo_count: got %0d want 1", bus.fifo_count);
    end
    #2;
    rst = 1'b1;
    #1;
    view = {bus.data_out, bus.busy, bus.bit_count, bus.fifo_count, bus.frames_sent, bus.load_ready};
    testsRun++;
    if (view !== RESET_VIEW) begin
      failCnt++;
      $display("FAIL reset_async: got %b want %b", view, RESET_VIEW);
    end
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    bus.ready_for_transfer_in = 1'b1;
    push_byte(8'hA5, 1'b1, "single_push");
    // Pushed on edge N into an empty FIFO, launched on edge N+1.
    score_frame("single", 1);
    tick();
    testsRun++;
    if (bus.frames_sent !== expFrames || bus.busy !== 1'b0) begin
      failCnt++;
      $display("FAIL single frames_sent/busy: got %0d/%0b want %0d/0",
               bus.frames_sent, bus.busy, expFrames);
    end
    bus.ready_for_transfer_in = 1'b0;
  endtask

  task automatic test_flow_control();
    logic [4:0] view;
    bus.ready_for_transfer_in = 1'b0;
    push_byte(8'h3C, 1'b1, "flow_push");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      view = {bus.data_out, bus.busy, bus.fifo_count};
      testsRun++;
      if (view !== {1'b0, 1'b0, CNT_W'(1)}) begin
        failCnt++;
        $display("FAIL flow_hold cycle %0d data_out/busy/fifo_count: got %b want 00001", i, view);
      end
    end
    @(posedge clk);
    #1;
    bus.ready_for_transfer_in = 1'b1;
    fork
      score_frame("flow", 1);
      begin
        // Drop ready while the frame is in DATA; it must still complete.
        repeat (5) @(posedge clk);
        #1;
        bus.ready_for_transfer_in = 1'b0;
      end
    join
    tick();
    testsRun++;
    if (bus.frames_sent !== expFrames || bus.fifo_count !== CNT_W'(0)) begin
      failCnt++;
      $display("FAIL flow frames_sent/fifo_count: got %0d/%0d want %0d/0",
               bus.frames_sent, bus.fifo_count, expFrames);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytesIn [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    bus.ready_for_transfer_in = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(bytesIn[i], (i < DEPTH), "full_push");
    @(negedge clk);
    testsRun++;
    if (bus.load_ready !== 1'b0 || bus.fifo_count !== CNT_W'(DEPTH)) begin
      failCnt++;
      $display("FAIL full load_ready/fifo_count: got %0b/%0d want 0/%0d",
               bus.load_ready, bus.fifo_count, DEPTH);
    end
    @(posedge clk);
    #1;
    bus.ready_for_transfer_in = 1'b1;
    // Every frame after the first is preceded by exactly one IDLE cycle.
    for (int i = 0; i < DEPTH; i++) score_frame("back_to_back", 1);
    tick();
    bus.ready_for_transfer_in = 1'b0;
    testsRun++;
    if (bus.frames_sent !== expFrames || bus.fifo_count !== CNT_W'(0) || bus.load_ready !== 1'b1) begin
      failCnt++;
      $display("FAIL back_to_back end frames_sent/fifo_count/load_ready: got %0d/%0d/%0b want %0d/0/1",
               bus.frames_sent, bus.fifo_count, bus.load_ready, expFrames);
    end
  endtask

  task automatic test_simultaneous();
    bus.ready_for_transfer_in = 1'b0;
    push_byte(8'hAA, 1'b1, "simul_fill");
    push_byte(8'hBB, 1'b1, "simul_fill");
    fork
      for (int i = 0; i < 3; i++) score_frame("simul", 1);
      begin
        bus.ready_for_transfer_in = 1'b1;
        push_byte(8'hCC, 1'b1, "simul_push");
        @(negedge clk);
        testsRun++;
        if (bus.fifo_count !== CNT_W'(2)) begin
          failCnt++;
          $display("FAIL simul fifo_count after push+pop: got %0d want 2", bus.fifo_count);
        end
      end
    join
    tick();
    bus.ready_for_transfer_in = 1'b0;
    testsRun++;
    if (bus.frames_sent !== expFrames || bus.fifo_count !== CNT_W'(0)) begin
      failCnt++;
      $display("FAIL simul end frames_sent/fifo_count: got %0d/%0d want %0d/0",
               bus.frames_sent, bus.fifo_count, expFrames);
    end
  endtask

  task automatic test_reset_mid_frame_and_wrap();
    logic [16:0] view;
    int          guard;
    bus.ready_for_transfer_in = 1'b0;
    push_byte(8'h5A, 1'b1, "abort_fill");
    push_byte(8'h66, 1'b1, "abort_fill");
    bus.ready_for_transfer_in = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!(bus.busy === 1'b1 && bus.bit_count === 3'd4) && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    testsRun++;
    if (guard >= 50) begin
      failCnt++;
      $display("FAIL abort reach DATA bit 4: got timeout after %0d cycles, want bit 4", guard);
    end
    // 5A bit 4 is 1, so the line is high right up to the reset.
    #2;
    rst = 1'b1;
    #1;
    view = {bus.data_out, bus.busy, bus.bit_count, bus.fifo_count, bus.frames_sent, bus.load_ready};
    testsRun++;
    if (view !== RESET_VIEW) begin
      failCnt++;
      $display("FAIL abort_reset: got %b want %b", view, RESET_VIEW);
    end
    expQ.delete();
    expFrames = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    // ready is still high; a flushed FIFO must not launch anything.
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.busy !== 1'b0 || bus.fifo_count !== CNT_W'(0) || bus.data_out !== 1'b0) begin
      failCnt++;
      $display("FAIL abort after-reset busy/fifo_count/data_out: got %0b/%0d/%0b want 0/0/0",
               bus.busy, bus.fifo_count, bus.data_out);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      push_byte(8'(i * 37 + 11), 1'b1, "wrap_push");
      score_frame("wrap", 1);
      tick();
      if (i == 254) begin
        testsRun++;
        if (bus.frames_sent !== 8'd255 || expFrames !== 8'd255) begin
          failCnt++;
          $display("FAIL wrap frames_sent at 255: got %0d want 255", bus.frames_sent);
        end
      end
    end
    testsRun++;
    if (bus.frames_sent !== expFrames || bus.frames_sent !== 8'd0) begin
      failCnt++;
      $display("FAIL wrap frames_sent after 256: got %0d want 0", bus.frames_sent);
    end
    bus.ready_for_transfer_in = 1'b0;
  endtask

  initial begin
    bus.load_valid            = 1'b0;
    bus.load_data             = 8'h00;
    bus.ready_for_transfer_in = 1'b0;
    test_reset();
    test_single_frame();
    test_flow_control();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_frame_and_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
